// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scanout path.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vga_color_t;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} vga_phase_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_FP        = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_FP        = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;
  localparam int DEF_SCALE_SHIFT = 2;
  localparam int DEF_RD_LATENCY  = 1;

  localparam bit DEF_SYNC_ACTIVE_LOW = 1'b1;

  localparam int CNT_W = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with an ACTIVE/FP/SYNC/BP phase FSM.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACT_LEN  = DEF_H_ACTIVE,
  parameter int FP_LEN   = DEF_H_FP,
  parameter int SYNC_LEN = DEF_H_SYNC,
  parameter int BP_LEN   = DEF_H_BP,
  parameter bit SYNC_ON  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output vga_phase_t       phase,
  output logic             sync,
  output logic             wrap
);

  localparam int FP_END   = ACT_LEN + FP_LEN;
  localparam int SYNC_END = FP_END + SYNC_LEN;
  localparam int TOTAL    = SYNC_END + BP_LEN;

  logic [CNT_W-1:0] count_next;
  vga_phase_t       phase_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      phase <= ACTIVE;
    end else begin
      count <= count_next;
      phase <= phase_next;
    end
  end

  // Phase only changes on the last count of the current interval.
  always_comb begin
    count_next = count;
    phase_next = phase;
    wrap       = 1'b0;
    if (en) begin
      count_next = count + CNT_W'(1);
      unique case (phase)
        ACTIVE: if (count == CNT_W'(ACT_LEN - 1))  phase_next = FP;
        FP:     if (count == CNT_W'(FP_END - 1))   phase_next = SYNC;
        SYNC:   if (count == CNT_W'(SYNC_END - 1)) phase_next = BP;
        BP: begin
          if (count == CNT_W'(TOTAL - 1)) begin
            count_next = '0;
            phase_next = ACTIVE;
            wrap       = 1'b1;
          end
        end
      endcase
    end
  end

  assign sync = (phase == SYNC) ? SYNC_ON : !SYNC_ON;

endmodule

// File: rtl/vga_scanout.sv
// VGA raster timing, frame-memory addressing and pin alignment.
// Optional built-in colour-bar source enabled by defining VGA_TESTPATTERN_EN.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter int SCALE_SHIFT     = DEF_SCALE_SHIFT,
  parameter int RD_LATENCY      = DEF_RD_LATENCY,
  parameter bit SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  vga_color_t i_color,
  input  logic       i_test_mode,
  output logic [7:0] o_pxlX,
  output logic [7:0] o_pxlY,
  output vga_color_t o_color,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output logic       o_frame_start,
  output logic       o_vblank
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIPE_LEN = RD_LATENCY + 2;
  localparam bit SYNC_ON  = !SYNC_ACTIVE_LOW;

  if (((H_ACTIVE >> SCALE_SHIFT) > 256) || ((V_ACTIVE >> SCALE_SHIFT) > 256) ||
      (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
      (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0) ||
      (RD_LATENCY < 1) || (H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_params
    $fatal(1, "vga_scanout: unsupported timing parameters");
  end

  logic [CNT_W-1:0]    h_cnt, v_cnt;
  vga_phase_t          h_phase, v_phase;
  logic                h_sync, v_sync, h_wrap, v_wrap;
  logic                de_p0;
  logic [PIPE_LEN-1:0] de_sr, hs_sr, vs_sr;
  logic                at_origin;
  vga_color_t          color_src;

  // Stage 0: raster counters
  vga_axis_counter #(
    .ACT_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .SYNC_ON(SYNC_ON)
  ) u_hcnt (
    .clk(i_clk), .rst(i_reset), .en(1'b1),
    .count(h_cnt), .phase(h_phase), .sync(h_sync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACT_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .SYNC_ON(SYNC_ON)
  ) u_vcnt (
    .clk(i_clk), .rst(i_reset), .en(h_wrap),
    .count(v_cnt), .phase(v_phase), .sync(v_sync), .wrap(v_wrap)
  );

  assign de_p0    = (h_phase == ACTIVE) && (v_phase == ACTIVE);
  assign o_vblank = (v_cnt >= CNT_W'(V_ACTIVE));

  // Stage 1 addresses memory; pin stage samples i_color RD_LATENCY later.
  // de_sr[PIPE_LEN-2] is the enable that lines up with the returned colour.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pxlX        <= '0;
      o_pxlY        <= '0;
      de_sr         <= '0;
      hs_sr         <= {PIPE_LEN{!SYNC_ON}};
      vs_sr         <= {PIPE_LEN{!SYNC_ON}};
      o_color       <= '0;
      at_origin     <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      o_pxlX        <= de_p0 ? 8'(h_cnt >> SCALE_SHIFT) : 8'd0;
      o_pxlY        <= de_p0 ? 8'(v_cnt >> SCALE_SHIFT) : 8'd0;
      de_sr         <= {de_sr[PIPE_LEN-2:0], de_p0};
      hs_sr         <= {hs_sr[PIPE_LEN-2:0], h_sync};
      vs_sr         <= {vs_sr[PIPE_LEN-2:0], v_sync};
      o_color       <= de_sr[PIPE_LEN-2] ? color_src : '0;
      at_origin     <= v_wrap;
      o_frame_start <= at_origin;
    end
  end

  assign o_de    = de_sr[PIPE_LEN-1];
  assign o_hsync = hs_sr[PIPE_LEN-1];
  assign o_vsync = vs_sr[PIPE_LEN-1];

`ifdef VGA_TESTPATTERN_EN
  localparam int X_SPAN = H_ACTIVE >> SCALE_SHIFT;

  logic [7:0] x_dly [RD_LATENCY];

  function automatic vga_color_t bar_color(input logic [10:0] bar);
    case (bar)
      11'd0:   bar_color = vga_color_t'(12'hFFF);
      11'd1:   bar_color = vga_color_t'(12'hFF0);
      11'd2:   bar_color = vga_color_t'(12'h0FF);
      11'd3:   bar_color = vga_color_t'(12'h0F0);
      11'd4:   bar_color = vga_color_t'(12'hF0F);
      11'd5:   bar_color = vga_color_t'(12'hF00);
      11'd6:   bar_color = vga_color_t'(12'h00F);
      default: bar_color = vga_color_t'(12'h000);
    endcase
  endfunction

  // X delayed to match the memory read so the bars line up with de.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < RD_LATENCY; i++) x_dly[i] <= '0;
    end else begin
      x_dly[0] <= o_pxlX;
      for (int i = 1; i < RD_LATENCY; i++) x_dly[i] <= x_dly[i-1];
    end
  end

  assign color_src = i_test_mode ?
    bar_color({x_dly[RD_LATENCY-1], 3'b000} / 11'(X_SPAN)) : i_color;
`else
  logic unused_test_mode;
  assign unused_test_mode = i_test_mode;
  assign color_src        = i_color;
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// Checks two scanout instances (read latency 1 and 3) cycle by cycle against a raster-position model.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 16,  VF = 1,  VS = 2,  VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int SS = 2;
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                        12'hF0F, 12'hF00, 12'h00F, 12'h000};
`ifdef VGA_TESTPATTERN_EN
  localparam bit TP_BUILT = 1'b1;
`else
  localparam bit TP_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic test_mode = 1'b0;
  bit   mem_rand = 1'b0;

  vga_color_t color1, color3, oc1, oc3;
  logic [7:0] px1, py1, px3, py3;
  logic hs1, vs1, de1, fs1, vb1, hs3, vs3, de3, fs3, vb3;

  logic [11:0] tbl [0:63][0:255];
  logic [7:0]  hx1, hy1;
  logic [7:0]  hx3 [3];
  logic [7:0]  hy3 [3];

  int t;
  int cyc = 0;
  int last_fs = -1;
  int de_fall [2] = '{-1, -1};
  logic prev_de [2] = '{1'b0, 1'b0};
  logic prev_hs [2] = '{1'b1, 1'b1};
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE_SHIFT(SS), .RD_LATENCY(1), .SYNC_ACTIVE_LOW(1'b1)
  ) dut1 (
    .i_clk(clk), .i_reset(rst), .i_color(color1), .i_test_mode(test_mode),
    .o_pxlX(px1), .o_pxlY(py1), .o_color(oc1), .o_hsync(hs1), .o_vsync(vs1),
    .o_de(de1), .o_frame_start(fs1), .o_vblank(vb1)
  );

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE_SHIFT(SS), .RD_LATENCY(3), .SYNC_ACTIVE_LOW(1'b1)
  ) dut3 (
    .i_clk(clk), .i_reset(rst), .i_color(color3), .i_test_mode(test_mode),
    .o_pxlX(px3), .o_pxlY(py3), .o_color(oc3), .o_hsync(hs3), .o_vsync(vs3),
    .o_de(de3), .o_frame_start(fs3), .o_vblank(vb3)
  );

  // Frame memory: data for an address appears RD_LATENCY clocks later.
  function automatic logic [11:0] mem_read(input logic [7:0] x, input logic [7:0] y);
    if (mem_rand) return tbl[y[5:0]][x];
    return {x[3:0], y[3:0], 4'hA};
  endfunction

  always @(posedge clk) begin
    hx1 <= px1;
    hy1 <= py1;
    hx3[0] <= px3; hx3[1] <= hx3[0]; hx3[2] <= hx3[1];
    hy3[0] <= py3; hy3[1] <= hy3[0]; hy3[2] <= hy3[1];
  end

  always_comb color1 = vga_color_t'(mem_read(hx1, hy1));
  always_comb color3 = vga_color_t'(mem_read(hx3[2], hy3[2]));

  // Clocks since the last reset edge, i.e. the raster position counted at stage 0.
  always @(posedge clk) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    assert (act === exp)
      else begin
        n_fail++;
        $error("FAIL %s cyc=%0d t=%0d actual=%0h required=%0h", tag, cyc, t, act, exp);
      end
  endtask

  task automatic check_dut(input int id, input int rd, input string tag,
                           input logic [7:0] ax, input logic [7:0] ay, input vga_color_t ac,
                           input logic ahs, input logic avs, input logic ade,
                           input logic afs, input logic avb);
    logic [7:0] ex, ey;
    logic [11:0] ec;
    logic ehs, evs, ede, efs, evb;
    int p, p1, h, v;
    ex = 8'd0; ey = 8'd0; ec = 12'd0; ehs = 1'b1; evs = 1'b1; ede = 1'b0;
    p = t - rd - 2;
    if (p >= 0) begin
      h = p % HT;
      v = (p / HT) % VT;
      ede = (h < HA) && (v < VA);
      ehs = !((h >= HA + HF) && (h < HA + HF + HS));
      evs = !((v >= VA + VF) && (v < VA + VF + VS));
      if (ede) begin
        if (TP_BUILT && test_mode) ec = BARS[((h >> SS) * 8) / (HA >> SS)];
        else                       ec = mem_read(8'(h >> SS), 8'(v >> SS));
      end
    end
    p1 = t - 1;
    efs = 1'b0;
    if (p1 >= 0) begin
      h = p1 % HT;
      v = (p1 / HT) % VT;
      if ((h < HA) && (v < VA)) begin
        ex = 8'(h >> SS);
        ey = 8'(v >> SS);
      end
      efs = (p1 % FRAME) == 0;
    end
    evb = ((t / HT) % VT) >= VA;
    chk({tag, "_pins"}, 32'({ac, ahs, avs, ade}), 32'({ec, ehs, evs, ede}));
    chk({tag, "_xy"},   32'({ax, ay}),            32'({ex, ey}));
    chk({tag, "_fs_vb"}, 32'({afs, avb}),          32'({efs, evb}));
    if (prev_de[id] && !ade) de_fall[id] = cyc;
    if (prev_hs[id] && !ahs && de_fall[id] >= 0 && (cyc - de_fall[id]) < HT)
      chk({tag, "_de_to_hsync"}, 32'(cyc - de_fall[id]), 32'(HF));
    prev_de[id] = ade;
    prev_hs[id] = ahs;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        last_fs = -1;
        de_fall[0] = -1;
        de_fall[1] = -1;
      end
      if (fs1 === 1'b1) begin
        if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(FRAME));
        last_fs = cyc;
      end
      check_dut(0, 1, "rd1", px1, py1, oc1, hs1, vs1, de1, fs1, vb1);
      check_dut(1, 3, "rd3", px3, py3, oc3, hs3, vs3, de3, fs3, vb3);
    end
  endtask

  initial begin
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 256; x++)
        tbl[y][x] = 12'($urandom);

    // Power-on reset, then a full frame with the coordinate-pattern memory.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    run(1);
    rst = 1'b0;
    run(FRAME + 5 * HT + 300);

    // One-clock reset mid-line at hcnt=300, vcnt=5; test pattern selected if built.
    rst = 1'b1;
    test_mode = 1'b1;
    mem_rand = 1'b1;
    run(1);
    rst = 1'b0;
    run(FRAME + 500);

    // Random reset point and length, random mode.
    run($urandom_range(1, 8000));
    rst = 1'b1;
    test_mode = 1'($urandom_range(0, 1));
    run($urandom_range(1, 3));
    rst = 1'b0;
    run(FRAME + 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
